// File: rtl/argmax_stream_scheduler_pkg.sv
// Shared definitions for the serial argmax decision stage.
// - SoftmaxInBitWidth : width of each signed class sum from the output-neuron accumulator
// - NumClasses        : class sums per frame (one per beat)
// - argmax_state_e    : scheduler FSM encoding (IDLE=0, ACCUM=1, DONE=2)
package argmax_stream_scheduler_pkg;

  localparam int unsigned SoftmaxInBitWidth = 16;
  localparam int unsigned NumClasses        = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } argmax_state_e;

endpackage

// File: rtl/argmax_mag_cmp.sv
// Magnitude of an incoming signed class sum and strict-greater compare against the running best.
// Ports:
// - sum_data : signed two's-complement class sum
// - best_mag : current best unsigned magnitude
// - mag      : unsigned magnitude of sum_data (most-negative maps to 2**(W-1), no saturation)
// - update   : mag > best_mag (strict, so ties keep the earlier class)
module argmax_mag_cmp #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] sum_data,
  input  logic [W-1:0] best_mag,
  output logic [W-1:0] mag,
  output logic         update
);

  always_comb begin
    // Modulo-2**W negate: 100..0 stays 100..0, which reads as 2**(W-1) unsigned.
    mag    = sum_data[W-1] ? ('0 - sum_data) : sum_data;
    update = (mag > best_mag);
  end

endmodule

// File: rtl/argmax_stream_scheduler.sv
// Serial argmax over NUM_CLASSES signed class sums arriving one per beat on a valid/ready stream.
// One shared magnitude comparator keeps a running |sum| maximum; the winning class index, its
// magnitude and a framing-error flag are presented on a valid/ready result port.
// Ports:
// - clk, rst           : clock, asynchronous active-high reset
// - flush              : synchronous abort of the partial frame and any pending result
// - sum_valid/ready    : input beat handshake; sum_data is class beat_cnt, sum_last ends a frame
// - result_valid/ready : result handshake; result_class/mag/err held stable while valid
// - frames_done        : count of results handed off, wraps
module argmax_stream_scheduler
  import argmax_stream_scheduler_pkg::*;
#(
  parameter int unsigned W           = SoftmaxInBitWidth,
  parameter int unsigned NUM_CLASSES = NumClasses,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic [W-1:0]     sum_data,
  input  logic             sum_last,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] result_class,
  output logic [W-1:0]     result_mag,
  output logic             result_err,
  output logic [CNT_W-1:0] frames_done
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e    state_q;
  logic [IDX_W-1:0] beat_cnt_q;
  logic [W-1:0]     best_mag_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             result_valid_q;
  logic [IDX_W-1:0] result_class_q;
  logic [W-1:0]     result_mag_q;
  logic             result_err_q;
  logic [CNT_W-1:0] frames_done_q;

  logic [W-1:0]     cur_mag;
  logic             cur_update;
  logic             is_final;
  logic             frame_end;
  logic             take_cur;
  logic [W-1:0]     win_mag;
  logic [IDX_W-1:0] win_idx;

  argmax_mag_cmp #(
    .W (W)
  ) u_mag_cmp (
    .sum_data (sum_data),
    .best_mag (best_mag_q),
    .mag      (cur_mag),
    .update   (cur_update)
  );

  always_comb begin
    is_final  = (beat_cnt_q == LastIdx);
    frame_end = sum_last | is_final;
    // The first beat of a frame always seeds the best registers.
    take_cur  = (state_q == StIdle) | cur_update;
    win_mag   = take_cur ? cur_mag : best_mag_q;
    win_idx   = take_cur ? ((state_q == StIdle) ? '0 : beat_cnt_q) : best_idx_q;
  end

  // Gated by rst so the producer never sees ready while the block is held in reset.
  assign sum_ready = ~rst & (state_q != StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      beat_cnt_q     <= '0;
      best_mag_q     <= '0;
      best_idx_q     <= '0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_mag_q   <= '0;
      result_err_q   <= 1'b0;
      frames_done_q  <= '0;
    end else if (flush) begin
      state_q        <= StIdle;
      beat_cnt_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (sum_valid) begin
            best_mag_q <= win_mag;
            best_idx_q <= win_idx;
            if (frame_end) begin
              state_q        <= StDone;
              beat_cnt_q     <= '0;
              result_valid_q <= 1'b1;
              result_class_q <= win_idx;
              result_mag_q   <= win_mag;
              // Error when exactly one of "final beat" and "sum_last" holds.
              result_err_q   <= is_final ^ sum_last;
            end else begin
              state_q    <= StAccum;
              beat_cnt_q <= beat_cnt_q + IDX_W'(1);
            end
          end
        end
        StDone: begin
          if (result_ready) begin
            state_q        <= StIdle;
            result_valid_q <= 1'b0;
            frames_done_q  <= frames_done_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_mag   = result_mag_q;
  assign result_err   = result_err_q;
  assign frames_done  = frames_done_q;

endmodule

// File: tb/tb_argmax_stream_scheduler.sv
// Directed and randomised checks of argmax_stream_scheduler with hand-computed expectations.
module tb_argmax_stream_scheduler;

  localparam int W     = 16;
  localparam int N     = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             sum_valid;
  logic             sum_ready;
  logic [W-1:0]     sum_data;
  logic             sum_last;
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] result_class;
  logic [W-1:0]     result_mag;
  logic             result_err;
  logic [CNT_W-1:0] frames_done;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;
  int vec[N];

  always #5 clk = ~clk;

  argmax_stream_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready),
    .sum_data     (sum_data),
    .sum_last     (sum_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_mag   (result_mag),
    .result_err   (result_err),
    .frames_done  (frames_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat has transferred.
  task automatic send_beat(input int d, input logic last);
    int n = 0;
    sum_valid = 1'b1;
    sum_data  = W'(d);
    sum_last  = last;
    while (!sum_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_accept", 32'(sum_ready), 1);
    @(negedge clk);
    sum_valid = 1'b0;
    sum_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit mark_last, input bit gaps);
    for (int k = 0; k < len; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
      send_beat(vec[k], mark_last && (k == len - 1));
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(result_valid), 1);
  endtask

  task automatic check_result(input string tag, input int cls, input int mag, input int err);
    check_eq({tag, "_class"}, 32'(result_class), cls);
    check_eq({tag, "_mag"}, 32'(result_mag), mag);
    check_eq({tag, "_err"}, 32'(result_err), err);
  endtask

  task automatic consume(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    exp_frames++;
    check_eq({tag, "_frames"}, 32'(frames_done), exp_frames);
    check_eq({tag, "_drop"}, 32'(result_valid), 0);
  endtask

  function automatic int ref_mag(input int v);
    logic [W-1:0] b;
    b = W'(v);
    return b[W-1] ? ((1 << W) - int'(b)) : int'(b);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, bcls, bmag, eerr;
    bit nolast;
    logic [IDX_W-1:0] hold_cls;
    logic [W-1:0] hold_mag;

    rst = 1'b1; flush = 1'b0; sum_valid = 1'b0; sum_data = '0; sum_last = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(sum_ready), 0);
    check_eq("rst_rvalid", 32'(result_valid), 0);
    check_eq("rst_frames", 32'(frames_done), 0);
    check_eq("rst_class", 32'(result_class), 0);
    check_eq("rst_mag", 32'(result_mag), 0);
    check_eq("rst_err", 32'(result_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(sum_ready), 1);

    // Basic frame, back-to-back, with latency check.
    vec = '{5, -3, 7, 2, 0, 1, -7, 6, 4, 3};
    for (int k = 0; k < N - 1; k++) send_beat(vec[k], 1'b0);
    check_eq("t1_early", 32'(result_valid), 0);
    send_beat(vec[N-1], 1'b1);
    check_eq("t1_latency", 32'(result_valid), 1);
    check_eq("t1_busy", 32'(sum_ready), 0);
    check_result("t1", 2, 7, 0);
    consume("t1");
    check_eq("t1_idle_ready", 32'(sum_ready), 1);

    // All equal negatives: lowest index wins.
    for (int k = 0; k < N; k++) vec[k] = -20;
    send_frame(N, 1'b1, 1'b0);
    wait_result("t2");
    check_result("t2", 0, 20, 0);
    consume("t2");

    // Most-negative sum on beat 4.
    vec = '{1, -2, 3, 4, 32768, 5, -6, 7, 8, 9};
    send_frame(N, 1'b1, 1'b0);
    wait_result("t3");
    check_result("t3", 4, 32768, 0);
    consume("t3");

    // Early sum_last on beat 5.
    vec = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0};
    send_frame(6, 1'b1, 1'b0);
    wait_result("t4");
    check_result("t4", 5, 6, 1);
    consume("t4");

    // Ten beats without sum_last.
    vec = '{3, -1, 4, -1, 5, -9, 2, 6, 5, 3};
    send_frame(N, 1'b0, 1'b0);
    wait_result("t5");
    check_result("t5", 5, 9, 1);

    // Hold off the consumer; offered beats must be ignored.
    hold_cls = result_class;
    hold_mag = result_mag;
    for (int i = 0; i < 20; i++) begin
      sum_valid = 1'b1;
      sum_data  = W'(1000);
      @(negedge clk);
      check_eq("t6_ready_low", 32'(sum_ready), 0);
      check_eq("t6_hold_valid", 32'(result_valid), 1);
      check_eq("t6_hold_class", 32'(result_class), 32'(hold_cls));
      check_eq("t6_hold_mag", 32'(result_mag), 32'(hold_mag));
    end
    sum_valid = 1'b0;
    check_eq("t6_frames_before", 32'(frames_done), exp_frames);
    consume("t6");
    check_eq("t6_idle_ready", 32'(sum_ready), 1);

    // Flush at beat 6, then a fresh frame.
    vec = '{500, 1, 2, 3, 4, 5, 0, 0, 0, 0};
    send_frame(6, 1'b0, 1'b0);
    sum_valid = 1'b1;
    sum_data  = W'(900);
    flush     = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    sum_valid = 1'b0;
    check_eq("t7_flush_rvalid", 32'(result_valid), 0);
    check_eq("t7_flush_frames", 32'(frames_done), exp_frames);
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(N, 1'b1, 1'b0);
    wait_result("t7");
    check_result("t7", 9, 10, 0);
    consume("t7");

    // Randomised frames with valid gaps against a reference argmax.
    for (int f = 0; f < 100; f++) begin
      len    = $urandom_range(1, N);
      nolast = (len == N) && ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 9))
          0:       vec[k] = 32768;
          1, 2, 3: vec[k] = int'($urandom_range(0, 14)) - 7;
          default: vec[k] = int'($urandom_range(0, 65535));
        endcase
      end
      bcls = 0;
      bmag = ref_mag(vec[0]);
      for (int k = 1; k < len; k++) begin
        if (ref_mag(vec[k]) > bmag) begin
          bmag = ref_mag(vec[k]);
          bcls = k;
        end
      end
      eerr = ((len < N) || nolast) ? 1 : 0;
      send_frame(len, !nolast, 1'b1);
      wait_result("rnd");
      check_result("rnd", bcls, bmag, eerr);
      consume("rnd");
    end
    check_eq("rnd_frames_total", 32'(frames_done), exp_frames);

    // Async reset while a result is pending.
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(N, 1'b1, 1'b0);
    wait_result("t8");
    #2;
    rst = 1'b1;
    #1;
    check_eq("t8_rst_rvalid", 32'(result_valid), 0);
    check_eq("t8_rst_frames", 32'(frames_done), 0);
    check_eq("t8_rst_ready", 32'(sum_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t8_post_ready", 32'(sum_ready), 1);
    check_eq("t8_post_class", 32'(result_class), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
